// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator behind a valid/ready
// handshake. The immediate is decoded combinationally from the incoming
// instruction. It is then captured into a main output register (m). A second
// skid register (k) holds one more entry while the consumer stalls.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 8,
  parameter int AUTO_DECODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    SRC_I     = 3'd0,
    SRC_S     = 3'd1,
    SRC_B     = 3'd2,
    SRC_U     = 3'd3,
    SRC_J     = 3'd4,
    SRC_SHAMT = 3'd5,
    SRC_RSV6  = 3'd6,
    SRC_RSV7  = 3'd7
  } imm_src_e;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  imm_src_e        src;
  logic            zero_legal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            illegal;
  logic            accept;
  entry_t          new_entry;
  entry_t          m;
  entry_t          k;

  wire       s      = in_instr[31];
  wire [6:0] opcode = in_instr[6:0];
  wire [2:0] funct3 = in_instr[14:12];

  // Pick the immediate format: explicit select, or decoded from the opcode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    src        = imm_src_e'(in_imm_src);
    zero_legal = 1'b0;
    if (AUTO_DECODE != 0) begin
      case (opcode)
        7'b0010011: src = (funct3 == 3'b001 || funct3 == 3'b101) ? SRC_SHAMT : SRC_I;
        7'b0000011, 7'b1100111, 7'b1110011: src = SRC_I;
        7'b0100011: src = SRC_S;
        7'b1100011: src = SRC_B;
        7'b0110111, 7'b0010111: src = SRC_U;
        7'b1101111: src = SRC_J;
        7'b0110011: begin
          src        = SRC_I;
          zero_legal = 1'b1;  // R-type: no immediate, but a legal instruction
        end
        default:    src = SRC_RSV7;
      endcase
    end
  end

  // Build the 32-bit immediate for the selected format; reserved gives 0 + illegal.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (src)
      SRC_I:     imm32 = {{20{s}}, in_instr[31:20]};
      SRC_S:     imm32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
      SRC_B:     imm32 = {{19{s}}, in_instr[31], in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      SRC_U:     imm32 = {in_instr[31:12], 12'b0};
      SRC_J:     imm32 = {{11{s}}, in_instr[31], in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
      SRC_SHAMT: imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                      : {27'b0, in_instr[24:20]};
      default:   illegal = 1'b1;
    endcase
    if (zero_legal) imm32 = '0;
  end

  // Sign-extend to XLEN; shift amounts have bit 31 clear, so they zero-extend.
  if (XLEN == 32) begin : g_x32
    assign imm_ext = imm32;
  end else begin : g_xwide
    assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
  end

  assign new_entry = '{valid: 1'b1, imm: imm_ext, tag: in_tag, illegal: illegal};

  // Ready depends only on the skid slot, never on out_ready.
  assign in_ready = !k.valid && !rst;
  assign accept   = in_valid && in_ready;

  // Main/skid register update: strict FIFO, at most one entry in flight in k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      k <= '0;
    end else if (k.valid) begin
      if (out_ready) begin
        // NOTE: non-blocking so m takes the old k and k.valid clears in the same edge.
        m       <= k;
        k.valid <= 1'b0;
      end
    end else if (accept) begin
      if (!m.valid || out_ready) m <= new_entry;
      else                       k <= new_entry;
    end else if (m.valid && out_ready) begin
      m.valid <= 1'b0;
    end
  end

  assign out_valid   = m.valid;
  assign out_imm     = m.imm;
  assign out_tag     = m.tag;
  assign out_illegal = m.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Three instances share one stimulus stream:
// XLEN=32 auto-decode (a32), XLEN=32 manual select (m32), XLEN=64 auto (a64).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        a32_in_ready, a32_valid, a32_illegal;
  logic [31:0] a32_imm;
  logic [7:0]  a32_tag;
  logic        m32_in_ready, m32_valid, m32_illegal;
  logic [31:0] m32_imm;
  logic [7:0]  m32_tag;
  logic        a64_in_ready, a64_valid, a64_illegal;
  logic [63:0] a64_imm;
  logic [7:0]  a64_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUTO_DECODE(1)) u_a32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a32_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(a32_valid), .out_ready(out_ready), .out_imm(a32_imm),
    .out_tag(a32_tag), .out_illegal(a32_illegal));

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUTO_DECODE(0)) u_m32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m32_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(m32_valid), .out_ready(out_ready), .out_imm(m32_imm),
    .out_tag(m32_tag), .out_illegal(m32_illegal));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .AUTO_DECODE(1)) u_a64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a64_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(a64_valid), .out_ready(out_ready), .out_imm(a64_imm),
    .out_tag(a64_tag), .out_illegal(a64_illegal));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Offer one instruction at a falling edge; return at the next falling edge.
  task automatic step(input logic [31:0] instr, input logic [2:0] src, input logic [7:0] tag);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    in_tag     = tag;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    out_ready  = 1'b1;

    // Reset state
    #2;
    chk("rst_in_ready", a32_in_ready, 0);
    chk("rst_out_valid", a32_valid, 0);
    chk("rst_out_imm", a32_imm, 0);
    chk("rst_out_tag", a32_tag, 0);
    chk("rst_out_illegal", a32_illegal, 0);
    chk("rst_a64_imm", a64_imm, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", a32_in_ready, 1);
    @(negedge clk);

    // Formats, out_ready=1, one-cycle latency
    step(32'hFFB10093, 3'b000, 8'h11);
    chk("addi_valid", a32_valid, 1);
    chk("addi_a32", a32_imm, 64'hFFFFFFFB);
    chk("addi_tag", a32_tag, 8'h11);
    chk("addi_a64", a64_imm, 64'hFFFFFFFFFFFFFFFB);
    chk("addi_m32_I", m32_imm, 64'hFFFFFFFB);

    step(32'h00512623, 3'b001, 8'h12);
    chk("sw_a32", a32_imm, 64'h0000000C);
    chk("sw_m32_S", m32_imm, 64'h0000000C);

    step(32'h00208863, 3'b000, 8'h13);
    chk("beq_a32", a32_imm, 64'h00000010);
    chk("beq_m32_I", m32_imm, 64'h00000002);
    chk("beq_m32_illegal", m32_illegal, 0);

    step(32'h00208863, 3'b010, 8'h14);
    chk("beq_m32_B", m32_imm, 64'h00000010);

    step(32'h00208863, 3'b111, 8'h15);
    chk("m32_rsv_imm", m32_imm, 0);
    chk("m32_rsv_illegal", m32_illegal, 1);
    chk("a32_ignores_src", a32_imm, 64'h00000010);

    step(32'h123450B7, 3'b000, 8'h16);
    chk("lui_a32", a32_imm, 64'h12345000);
    chk("lui_a64", a64_imm, 64'h0000000012345000);

    step(32'hFFDFF0EF, 3'b000, 8'h17);
    chk("jal_a32", a32_imm, 64'hFFFFFFFC);
    chk("jal_tag", a32_tag, 8'h17);

    step(32'h01F09093, 3'b000, 8'h18);
    chk("slli_a32", a32_imm, 64'h0000001F);
    chk("slli_illegal", a32_illegal, 0);

    step(32'h00000033, 3'b000, 8'h19);
    chk("rtype_imm", a32_imm, 0);
    chk("rtype_illegal", a32_illegal, 0);

    step(32'h0000007F, 3'b000, 8'h1A);
    chk("badop_imm", a32_imm, 0);
    chk("badop_illegal", a32_illegal, 1);
    chk("badop_a64_illegal", a64_illegal, 1);

    step(32'h800000B7, 3'b000, 8'h1B);
    chk("lui_neg_a64", a64_imm, 64'hFFFFFFFF80000000);
    chk("lui_neg_a32", a32_imm, 64'h80000000);

    step(32'h03F09093, 3'b000, 8'h1C);
    chk("shamt6_a64", a64_imm, 64'h000000000000003F);
    chk("shamt5_a32", a32_imm, 64'h0000001F);

    // Drain: no offer, consumer ready -> output goes invalid
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", a32_valid, 0);

    // Back-pressure: tags 1,2,3 offered back-to-back with out_ready=0
    out_ready = 1'b0;
    chk("bp_ready_t1", a32_in_ready, 1);
    step(32'hFFB10093, 3'b000, 8'd1);
    chk("bp_ready_t2", a32_in_ready, 1);
    chk("bp_out_t1", a32_tag, 8'd1);
    step(32'hFFB10093, 3'b000, 8'd2);
    chk("bp_ready_t3", a32_in_ready, 0);
    chk("bp_hold_valid", a32_valid, 1);
    chk("bp_hold_tag", a32_tag, 8'd1);
    step(32'hFFB10093, 3'b000, 8'd3);
    chk("bp_still_t1", a32_tag, 8'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_t2", a32_tag, 8'd2);
    chk("bp_ready_after_drain", a32_in_ready, 1);
    @(negedge clk);
    chk("bp_out_t3", a32_tag, 8'd3);
    chk("bp_out_t3_valid", a32_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_dup", a32_valid, 0);

    // Reset mid-operation with M and K both full
    out_ready = 1'b0;
    step(32'h00512623, 3'b000, 8'd4);
    step(32'h00512623, 3'b000, 8'd5);
    in_valid = 1'b0;
    chk("mid_full_ready", a32_in_ready, 0);
    chk("mid_full_valid", a32_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", a32_valid, 0);
    chk("mid_rst_ready", a32_in_ready, 0);
    chk("mid_rst_tag", a32_tag, 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_no_glitch", a32_valid, 0);
    chk("post_rst_ready", a32_in_ready, 1);
    step(32'h123450B7, 3'b000, 8'd6);
    chk("post_rst_valid", a32_valid, 1);
    chk("post_rst_tag", a32_tag, 8'd6);
    chk("post_rst_imm", a32_imm, 64'h12345000);
    in_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
